usb_display_register: RTL and testbench

USB_DISPLAY_REGISTER -- requirements
Module: usb_display_register

---
 rtl/usb_display_register_pkg.sv | 12 +
 rtl/usb_display_timeout.sv | 57 +++++
 rtl/usb_display_register.sv | 104 ++++++++++
 tb/tb_usb_display_register.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/usb_display_register_pkg.sv
// Shared types and constants for the USB-controlled display register.
package usb_display_register_pkg;

  localparam int unsigned REG_NUM_W         = 5;
  localparam int unsigned BYTE_IDX_W        = 3;
  localparam int unsigned MAX_DISPLAY_BYTES = 8;
  localparam int unsigned BLINK_HALF_PERIOD = 50;

  typedef logic [7:0]                     display_byte_t;
  typedef logic [8*MAX_DISPLAY_BYTES-1:0] display_word_t;

endpackage

// File: rtl/usb_display_timeout.sv
// USB display ownership counter; with USB_DISPLAY_BLINK_EN defined it also
// provides the 1 Hz blink phase.
module usb_display_timeout
  import usb_display_register_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = 500
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic commit,
`ifdef USB_DISPLAY_BLINK_EN
  output logic blink_phase,
`endif
  output logic usb_active
);

  localparam int unsigned CW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;

  logic [CW-1:0] cnt;

  // A zero count never decrements, so TIMEOUT_TICKS==0 holds ownership until reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt        <= '0;
      usb_active <= 1'b0;
    end else if (commit) begin
      cnt        <= CW'(TIMEOUT_TICKS);
      usb_active <= 1'b1;
    end else if (clk_en && cnt != '0) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1))
        usb_active <= 1'b0;
    end
  end

`ifdef USB_DISPLAY_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_HALF_PERIOD);

  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (clk_en) begin
      if (blink_cnt == BW'(BLINK_HALF_PERIOD - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/usb_display_register.sv
// Wishbone-writable display override with shadow/commit and ownership timeout.
// Optional feature macro: USB_DISPLAY_BLINK_EN (bit DW-1 enables HEX blinking).
module usb_display_register
  import usb_display_register_pkg::*;
#(
  parameter int unsigned ADDR          = 2,
  parameter int unsigned DISPLAY_BYTES = 6,
  parameter int unsigned TIMEOUT_TICKS = 500,
  localparam int unsigned DW           = 8 * DISPLAY_BYTES
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [7:0]    wb_adr_i,
  input  logic [7:0]    wb_dat_i,
  output logic [7:0]    wb_dat_o,
  output logic          wb_ack_o,
  input  logic [DW-1:0] display_i,
  output logic [DW-1:0] display_o,
  output logic          usb_active
);

  localparam logic [REG_NUM_W-1:0]  REG_SEL  = REG_NUM_W'(ADDR);
  localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(DISPLAY_BYTES - 1);

  logic [REG_NUM_W-1:0]  reg_num;
  logic [BYTE_IDX_W-1:0] byte_idx;
  logic                  hit, wr_hit, rd_hit, commit;
  logic [DW-1:0]         shadow, shadow_next, active;
  logic [DW-1:0]         disp_next;
  display_byte_t         rd_byte;

  assign reg_num  = wb_adr_i[7:3];
  assign byte_idx = wb_adr_i[2:0];
  assign hit      = wb_cyc_i & wb_stb_i & (reg_num == REG_SEL) &
                    ({1'b0, byte_idx} < 4'(DISPLAY_BYTES)) & ~wb_ack_o;
  assign wr_hit   = hit & wb_we_i;
  assign rd_hit   = hit & ~wb_we_i;
  assign commit   = wr_hit & (byte_idx == LAST_IDX);

  // The committed word is the shadow with the final byte merged in this cycle.
  always_comb begin
    shadow_next = shadow;
    rd_byte     = '0;
    for (int unsigned b = 0; b < DISPLAY_BYTES; b++) begin
      if (byte_idx == BYTE_IDX_W'(b)) begin
        rd_byte = active[b*8 +: 8];
        if (wr_hit)
          shadow_next[b*8 +: 8] = wb_dat_i;
      end
    end
  end

`ifdef USB_DISPLAY_BLINK_EN
  localparam int unsigned   BLINK_BITS = (DW < 28) ? DW : 28;
  localparam logic [DW-1:0] BLINK_MASK = {DW{1'b1}} >> (DW - BLINK_BITS);

  logic blink_phase;

  always_comb begin
    disp_next = usb_active ? active : display_i;
    if (usb_active && active[DW-1] && blink_phase)
      disp_next = disp_next | BLINK_MASK;
  end
`else
  always_comb begin
    disp_next = usb_active ? active : display_i;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_ack_o  <= 1'b0;
      wb_dat_o  <= '0;
      shadow    <= '0;
      active    <= '0;
      display_o <= '0;
    end else begin
      wb_ack_o  <= hit;
      wb_dat_o  <= rd_hit ? rd_byte : '0;
      shadow    <= shadow_next;
      if (commit)
        active <= shadow_next;
      display_o <= disp_next;
    end
  end

  usb_display_timeout #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) u_timeout (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .commit     (commit),
`ifdef USB_DISPLAY_BLINK_EN
    .blink_phase(blink_phase),
`endif
    .usb_active (usb_active)
  );

endmodule

// File: tb/tb_usb_display_register.sv
// Directed, table-driven bench for usb_display_register (TIMEOUT_TICKS=3).
module tb_usb_display_register;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b0;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [7:0]  wb_adr_i = '0, wb_dat_i = '0;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;
  logic [47:0] display_i = '0;
  logic [47:0] display_o;
  logic        usb_active;

  int nvec = 0;
  int nmis = 0;
  int ticks = 0;

  always #5 clk = ~clk;

  usb_display_register #(
    .ADDR(2),
    .DISPLAY_BYTES(6),
    .TIMEOUT_TICKS(3)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .display_i(display_i), .display_o(display_o),
    .usb_active(usb_active)
  );

  typedef struct {
    logic [7:0]  adr;
    logic [7:0]  dat;
    logic        we;
    int          exp_acks;
    logic [7:0]  exp_rdata;
    logic [47:0] exp_disp;
    logic        exp_active;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc_edge();
    @(posedge clk);
    #1;
  endtask

  // Runs one bus access over three cycles, counting acks and grabbing read data.
  task automatic bus(input logic [7:0] a, input logic [7:0] d, input logic we,
                     output int acks, output logic [7:0] rdata);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = a; wb_dat_i = d;
    acks = 0;
    rdata = 8'hxx;
    for (int i = 0; i < 3; i++) begin
      cyc_edge();
      if (i == 0) rdata = wb_dat_o;
      if (wb_ack_o) begin
        acks++;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d, output int acks);
    logic [7:0] rd;
    bus(a, d, 1'b1, acks, rd);
  endtask

  task automatic tick();
    clk_en = 1'b1;
    cyc_edge();
    clk_en = 1'b0;
    ticks++;
  endtask

  initial begin
    int          acks;
    logic [7:0]  rdata;
    logic [47:0] exp_disp;
    int          nblink;

    vecs[0]  = '{8'h10, 8'hAA, 1'b1, 1, 8'h00, 48'h0123456789AB, 1'b0};
    vecs[1]  = '{8'h11, 8'hBB, 1'b1, 1, 8'h00, 48'h0123456789AB, 1'b0};
    vecs[2]  = '{8'h12, 8'hCC, 1'b1, 1, 8'h00, 48'h0123456789AB, 1'b0};
    vecs[3]  = '{8'h13, 8'hDD, 1'b1, 1, 8'h00, 48'h0123456789AB, 1'b0};
    vecs[4]  = '{8'h14, 8'hEE, 1'b1, 1, 8'h00, 48'h0123456789AB, 1'b0};
    vecs[5]  = '{8'h15, 8'hFF, 1'b1, 1, 8'h00, 48'hFFEEDDCCBBAA, 1'b1};
    vecs[6]  = '{8'h18, 8'h55, 1'b1, 0, 8'h00, 48'hFFEEDDCCBBAA, 1'b1};
    vecs[7]  = '{8'h16, 8'h55, 1'b1, 0, 8'h00, 48'hFFEEDDCCBBAA, 1'b1};
    vecs[8]  = '{8'h12, 8'h00, 1'b0, 1, 8'hCC, 48'hFFEEDDCCBBAA, 1'b1};
    vecs[9]  = '{8'h15, 8'h00, 1'b0, 1, 8'hFF, 48'hFFEEDDCCBBAA, 1'b1};
    vecs[10] = '{8'h1A, 8'h00, 1'b0, 0, 8'h00, 48'hFFEEDDCCBBAA, 1'b1};
    vecs[11] = '{8'h15, 8'h11, 1'b1, 1, 8'h00, 48'h11EEDDCCBBAA, 1'b1};

    // Reset and release
    display_i = 48'h0123456789AB;
    reset = 1'b0;
    cyc_edge(); cyc_edge();
    chk("rst_display", 64'(display_o), 64'h0);
    chk("rst_active", 64'(usb_active), 64'h0);
    chk("rst_ack", 64'(wb_ack_o), 64'h0);
    chk("rst_dat", 64'(wb_dat_o), 64'h0);
    reset = 1'b1;
    ticks = 0;
    cyc_edge(); cyc_edge();
    chk("release_display", 64'(display_o), 64'h0123456789AB);
    chk("release_active", 64'(usb_active), 64'h0);

    for (int i = 0; i < 12; i++) begin
      bus(vecs[i].adr, vecs[i].dat, vecs[i].we, acks, rdata);
      chk($sformatf("v%0d_acks", i), 64'(acks), 64'(vecs[i].exp_acks));
      chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_display", i), 64'(display_o), 64'(vecs[i].exp_disp));
      chk($sformatf("v%0d_active", i), 64'(usb_active), 64'(vecs[i].exp_active));
    end

    // Ownership expiry after three ticks
    display_i = 48'hA5A55A5A0F0F;
    tick(); chk("to_t1_active", 64'(usb_active), 64'h1);
    tick(); chk("to_t2_active", 64'(usb_active), 64'h1);
    chk("to_t2_display", 64'(display_o), 64'h11EEDDCCBBAA);
    tick(); chk("to_t3_active", 64'(usb_active), 64'h0);
    cyc_edge(); cyc_edge();
    chk("to_release_display", 64'(display_o), 64'hA5A55A5A0F0F);

    // Commit coinciding with the expiring tick reloads the counter
    wr(8'h15, 8'h22, acks);
    chk("co_acks", 64'(acks), 64'h1);
    chk("co_display", 64'(display_o), 64'h22EEDDCCBBAA);
    tick(); tick();
    clk_en = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 8'h15; wb_dat_i = 8'h33;
    cyc_edge();
    clk_en = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    ticks++;
    chk("co_tick_ack", 64'(wb_ack_o), 64'h1);
    chk("co_tick_active", 64'(usb_active), 64'h1);
    cyc_edge();
    chk("co_tick_ack_width", 64'(wb_ack_o), 64'h0);
    chk("co_tick_display", 64'(display_o), 64'h33EEDDCCBBAA);
    tick(); chk("co_r1_active", 64'(usb_active), 64'h1);
    tick(); chk("co_r2_active", 64'(usb_active), 64'h1);
    tick(); chk("co_r3_active", 64'(usb_active), 64'h0);

    // Partial shadow is discarded by reset
    for (int b = 0; b < 5; b++) begin
      wr(8'h10 + 8'(b), 8'h12 + 8'(b), acks);
      chk($sformatf("part_b%0d_acks", b), 64'(acks), 64'h1);
    end
    reset = 1'b0;
    cyc_edge(); cyc_edge();
    chk("rst2_display", 64'(display_o), 64'h0);
    chk("rst2_active", 64'(usb_active), 64'h0);
    reset = 1'b1;
    ticks = 0;
    cyc_edge(); cyc_edge();
    chk("rst2_release_display", 64'(display_o), 64'hA5A55A5A0F0F);
    wr(8'h15, 8'h01, acks);
    chk("discard_acks", 64'(acks), 64'h1);
    chk("discard_display", 64'(display_o), 64'h010000000000);
    chk("discard_active", 64'(usb_active), 64'h1);

    // Top bit: blink enable when the feature is built in, plain storage otherwise
    wr(8'h15, 8'h80, acks);
    chk("b47_display", 64'(display_o), 64'h800000000000);
    bus(8'h15, 8'h00, 1'b0, acks, rdata);
    chk("b47_readback", 64'(rdata), 64'h80);
`ifdef USB_DISPLAY_BLINK_EN
    nblink = 110;
`else
    nblink = 4;
`endif
    for (int k = 0; k < nblink; k++) begin
      tick();
      wr(8'h15, 8'h80, acks);
      exp_disp = 48'h800000000000;
`ifdef USB_DISPLAY_BLINK_EN
      if (((ticks / 50) % 2) == 1) exp_disp = 48'h80000FFFFFFF;
`endif
      chk($sformatf("blink_t%0d", ticks), 64'(display_o), 64'(exp_disp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
